// File: rtl/counter_display_if.sv
// Button inputs and seven-segment outputs of counter_display, grouped for port connection.
interface counter_display_if;
    logic       increment;
    logic       decrease;
    logic [6:0] display_one_out;
    logic [6:0] display_two_out;

    modport master (
        output increment,
        output decrease,
        input  display_one_out,
        input  display_two_out
    );

    modport slave (
        input  increment,
        input  decrease,
        output display_one_out,
        output display_two_out
    );
endinterface

// File: rtl/counter_display.sv
// Two-digit BCD up/down counter driven by push buttons, with active-low seven-segment decode.
// Optional per-button debouncer enabled by defining COUNTER_DEBOUNCE_EN.
module counter_display #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input logic               clk,
    input logic               reset,
    counter_display_if.slave  bus
);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
        $error("DEBOUNCE_CYCLES out of range 2..65535");
    end

    // Index 0 = increment, index 1 = decrease.
    logic [1:0] btn_raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] level;
    logic [1:0] level_d;
    logic [1:0] pulse;

    assign btn_raw = {bus.decrease, bus.increment};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

`ifdef COUNTER_DEBOUNCE_EN
    logic [15:0] db_cnt [2];
    logic [1:0]  db_level;

    // Accepted level flips only after the raw level has disagreed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_level <= '0;
            for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == 16'(DEBOUNCE_CYCLES - 1)) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign level = db_level;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) level_d <= '0;
        else       level_d <= level;
    end

    assign pulse = level & ~level_d;

    logic [3:0] units;
    logic [3:0] tens;
    logic       do_inc;
    logic       do_dec;

    assign do_inc = pulse[0] & ~pulse[1];
    assign do_dec = pulse[1] & ~pulse[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            units <= '0;
            tens  <= '0;
        end else if (do_inc) begin
            if (units == 4'd9) begin
                units <= '0;
                tens  <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
            end else begin
                units <= units + 4'd1;
            end
        end else if (do_dec) begin
            if (units == 4'd0) begin
                units <= 4'd9;
                tens  <= (tens == 4'd0) ? 4'd9 : tens - 4'd1;
            end else begin
                units <= units - 4'd1;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign bus.display_one_out = seg7(units);
    assign bus.display_two_out = seg7(tens);

endmodule

// File: tb/tb_counter_display.sv
// Directed bench for counter_display; define COUNTER_DEBOUNCE_EN to exercise the debouncer.
module tb_counter_display;

    localparam int unsigned DEB = 4;
`ifdef COUNTER_DEBOUNCE_EN
    localparam int unsigned DEBX = DEB;
`else
    localparam int unsigned DEBX = 0;
`endif
    localparam int unsigned LAT = 3 + DEBX;
    localparam int unsigned LOW = 4 + DEBX;

    logic clk = 1'b0;
    logic reset;

    counter_display_if bus ();

    counter_display #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [6:0] seg [10];
    int unsigned applied    = 0;
    int unsigned miscompares = 0;

    typedef struct {
        logic        inc;
        logic        dec;
        int unsigned hold;
        int unsigned tens;
        int unsigned units;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input int unsigned t, input int unsigned u);
        applied++;
        if (bus.display_two_out !== seg[t] || bus.display_one_out !== seg[u]) begin
            miscompares++;
            $display("FAIL %s: got two=%b one=%b, expected two=%b one=%b (%0d%0d)",
                     name, bus.display_two_out, bus.display_one_out, seg[t], seg[u], t, u);
        end
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic inc, input logic dec, input int unsigned hold);
        bus.increment = inc;
        bus.decrease  = dec;
        cycles(hold + DEBX);
        bus.increment = 1'b0;
        bus.decrease  = 1'b0;
        cycles(LOW);
    endtask

    initial begin
        seg[0] = 7'b1000000; seg[1] = 7'b1111001; seg[2] = 7'b0100100;
        seg[3] = 7'b0110000; seg[4] = 7'b0011001; seg[5] = 7'b0010010;
        seg[6] = 7'b0000010; seg[7] = 7'b1111000; seg[8] = 7'b0000000;
        seg[9] = 7'b0010000;

        vecs[0]  = '{1'b0, 1'b1, 3, 9, 9};
        vecs[1]  = '{1'b1, 1'b0, 3, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 3, 0, 1};
        vecs[3]  = '{1'b1, 1'b0, 3, 0, 2};
        vecs[4]  = '{1'b1, 1'b0, 3, 0, 3};
        vecs[5]  = '{1'b1, 1'b0, 3, 0, 4};
        vecs[6]  = '{1'b1, 1'b0, 3, 0, 5};
        vecs[7]  = '{1'b1, 1'b0, 3, 0, 6};
        vecs[8]  = '{1'b1, 1'b0, 3, 0, 7};
        vecs[9]  = '{1'b1, 1'b0, 3, 0, 8};
        vecs[10] = '{1'b1, 1'b0, 3, 0, 9};
        vecs[11] = '{1'b1, 1'b0, 3, 1, 0};
        vecs[12] = '{1'b1, 1'b0, 3, 1, 1};
        vecs[13] = '{1'b1, 1'b0, 3, 1, 2};
        vecs[14] = '{1'b0, 1'b1, 3, 1, 1};
        vecs[15] = '{1'b0, 1'b1, 3, 1, 0};
        vecs[16] = '{1'b0, 1'b1, 3, 0, 9};
        vecs[17] = '{1'b0, 1'b1, 3, 0, 8};
        vecs[18] = '{1'b0, 1'b1, 3, 0, 7};
        vecs[19] = '{1'b0, 1'b1, 3, 0, 6};
        vecs[20] = '{1'b0, 1'b1, 3, 0, 5};
        vecs[21] = '{1'b1, 1'b1, 5, 0, 5};
        vecs[22] = '{1'b1, 1'b0, 20, 0, 6};

        bus.increment = 1'b0;
        bus.decrease  = 1'b0;
        reset = 1'b1;
        #1 check("reset_state", 0, 0);
        cycles(2);
        reset = 1'b0;
        cycles(10);
        check("idle_after_reset", 0, 0);

        for (int i = 0; i < 23; i++) begin
            press(vecs[i].inc, vecs[i].dec, vecs[i].hold);
            check($sformatf("vec%0d", i), vecs[i].tens, vecs[i].units);
        end

        // Latency: change must land exactly on edge LAT after first sample.
        bus.increment = 1'b1;
        cycles(LAT - 1);
        check("latency_before", 0, 6);
        cycles(1);
        check("latency_at", 0, 7);
        cycles(3);
        bus.increment = 1'b0;
        cycles(LOW);
        check("latency_after", 0, 7);

`ifdef COUNTER_DEBOUNCE_EN
        bus.increment = 1'b1;
        cycles(2);
        bus.increment = 1'b0;
        cycles(20);
        check("glitch_ignored", 0, 7);
        bus.increment = 1'b1;
        cycles(8);
        bus.increment = 1'b0;
        cycles(LOW + 4);
        check("debounced_press", 0, 8);
`endif

        // Reset mid-press discards the pending step.
        bus.increment = 1'b1;
        cycles(1);
        #2 reset = 1'b1;
        #1 check("reset_async_midpress", 0, 0);
        bus.increment = 1'b0;
        cycles(2);
        reset = 1'b0;
        cycles(LAT + 4);
        check("midpress_discarded", 0, 0);

        // Button held through reset release counts once.
        reset = 1'b1;
        bus.increment = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(LAT - 1);
        check("held_reset_before", 0, 0);
        cycles(1);
        check("held_reset_counted", 0, 1);
        cycles(10);
        check("held_reset_once", 0, 1);
        bus.increment = 1'b0;
        cycles(LOW);

        for (int i = 0; i < 36; i++) press(1'b1, 1'b0, 3);
        check("reach_37", 3, 7);
        #2 reset = 1'b1;
        #1 check("reset_between_edges", 0, 0);
        cycles(2);
        reset = 1'b0;
        cycles(10);
        check("idle_after_37_reset", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/counter_display.md
COUNTER_DISPLAY -- requirements
Module: counter_display

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable clk cycles required before a button level is accepted; used only when COUNTER_DEBOUNCE_EN is defined; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 increment  input  1  asynchronous push-button level; each accepted press adds 1 to the count.
REQ-005 decrease  input  1  asynchronous push-button level; each accepted press subtracts 1 from the count.
REQ-006 display_one_out  output  7  seven-segment pattern of the units digit, bit order {g,f,e,d,c,b,a}, active-low.
REQ-007 display_two_out  output  7  seven-segment pattern of the tens digit, same bit order and polarity.

Function
REQ-008 Count SHALL be held as two BCD digits, units and tens, 4 bits each, with range 00..99.
REQ-009 Each button input SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 A press SHALL be detected as a rising edge of the synchronized (and, if enabled, debounced) level, giving a one-cycle pulse; holding a button produces exactly one step.
REQ-011 Increment pulse alone: count SHALL be +1 with decimal carry; 09->10, 99->00 (wrap).
REQ-012 Decrease pulse alone: count SHALL be -1 with decimal borrow; 10->09, 00->99 (wrap).
REQ-013 Increment and decrease pulses in the same cycle: count SHALL be unchanged.
REQ-014 Latency with debounce compiled out: the count changes on the 3rd rising clk edge, counting the first edge at which the input is sampled high as edge 1.
REQ-015 Outputs SHALL be combinational decodes of the digit registers; no extra pipeline stage.
REQ-016 Decode table (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-017 A digit register value of 10..15 is unreachable; the decoder SHALL output 1111111 (blank) for it.

Reset
REQ-018 Asserting reset SHALL immediately clear both digits to 0 and all synchronizer, edge-detect and debounce state to 0, independent of clk.
REQ-019 During reset and until the first count change, both outputs SHALL be 1000000 ("00").
REQ-020 A button held high through reset deassertion SHALL be counted once, on the edge detected after release from reset.
REQ-021 Reset asserted mid-press SHALL discard the pending press.

Configuration
REQ-022 With macro COUNTER_DEBOUNCE_EN defined, each synchronized input SHALL feed a debouncer: the accepted level changes only after the raw synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; glitches shorter than that SHALL be ignored; latency grows by DEBOUNCE_CYCLES cycles.
REQ-023 Without COUNTER_DEBOUNCE_EN, the synchronized level SHALL drive edge detection directly, and no debounce logic or counter SHALL be present.

Verification
REQ-024 Reset assert -> both outputs 1000000; release with both buttons low for 10 cycles -> outputs unchanged.
REQ-025 Debounce off: 12 separate increment presses (each high 3 cycles, low 3 cycles) -> display_two_out 1111001, display_one_out 0100100 ("12"); the count updates on the 3rd edge of each press.
REQ-026 From 00, one decrease press -> "99" (0010000/0010000); then one increment press -> "00".
REQ-027 Count 05, increment and decrease rising in the same cycle and held 5 cycles -> count stays 05; a 20-cycle increment hold -> exactly one step to 06.
REQ-028 COUNTER_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 2-cycle increment glitch -> no change; 8-cycle press -> exactly +1.
REQ-029 Reset asserted between clk edges at count 37 -> outputs show "00" before the next clk edge.
